// File: rtl/evu_counter_bank.sv
// ============================================================================
// evu_counter_bank
// ----------------------------------------------------------------------------
// Event-counting unit for the CVA6 performance-monitoring path.
//
// NUM_CH independent channels each pick one of NUM_EVT event sources and
// accumulate that source's multi-bit per-cycle increment. Multi-commit-port
// events therefore count exactly. Event 0 is reserved and never counts.
// Event 1 is the cycle source, which the environment drives like any other
// event.
//
// Pipeline (fixed latency, no stalls):
//   stage 1 : inc_q[c] <= selected, gated increment of channel c
//   stage 2 : cnt_q[c] <= cnt_q[c] + inc_q[c] (modulo 2^CNT_W)
// An event in cycle t is visible on cnt_o in cycle t+2.
//
// Optional feature (compile-time macro EVU_OVF_IRQ_EN):
//   defined   : irq_o is a register of |ovf_o. It rises one cycle after any
//               overflow flag sets. It falls one cycle after all flags clear.
//   undefined : irq_o is tied to 0. The port stays so the interface does
//               not change between builds.
//
// Ports
//   clk_i        in   1                clock
//   rst_ni       in   1                synchronous active-low reset
//   evt_inc_i    in   NUM_EVT*INC_W    per-event increment; slice e = event e
//   freeze_i     in   1                global count inhibit (stage 1 only)
//   cfg_we_i     in   1                channel config write strobe
//   cfg_ch_i     in   $clog2(NUM_CH)   channel addressed by cfg/cnt writes
//   cfg_sel_i    in   $clog2(NUM_EVT)  event select written to the channel
//   cfg_en_i     in   1                channel enable written to the channel
//   cnt_we_i     in   1                counter preload strobe
//   cnt_wdata_i  in   CNT_W            counter preload value
//   ovf_clr_i    in   NUM_CH           per-channel sticky overflow clear
//   cnt_o        out  NUM_CH*CNT_W     registered counter values
//   ovf_o        out  NUM_CH           sticky overflow flags
//   irq_o        out  1                overflow interrupt
// ============================================================================
module evu_counter_bank #(
    parameter  int NUM_CH  = 4,
    parameter  int NUM_EVT = 16,
    parameter  int CNT_W   = 64,
    parameter  int INC_W   = 2,
    localparam int CH_W    = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
    localparam int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_EVT*INC_W-1:0] evt_inc_i,
    input  logic                     freeze_i,
    input  logic                     cfg_we_i,
    input  logic [CH_W-1:0]          cfg_ch_i,
    input  logic [SEL_W-1:0]         cfg_sel_i,
    input  logic                     cfg_en_i,
    input  logic                     cnt_we_i,
    input  logic [CNT_W-1:0]         cnt_wdata_i,
    input  logic [NUM_CH-1:0]        ovf_clr_i,
    output logic [NUM_CH*CNT_W-1:0]  cnt_o,
    output logic [NUM_CH-1:0]        ovf_o,
    output logic                     irq_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]  sel_q [NUM_CH];   // per-channel event select
    logic [NUM_CH-1:0] en_q;             // per-channel enable
    logic [INC_W-1:0]  inc_q [NUM_CH];   // stage-1 captured increment
    logic [CNT_W-1:0]  cnt_q [NUM_CH];   // stage-2 counters
    logic [NUM_CH-1:0] ovf_q;            // sticky overflow flags

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [INC_W-1:0]  inc_d [NUM_CH];
    logic [CNT_W:0]    sum   [NUM_CH];   // one extra bit holds the carry-out
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_d;

    logic              ch_valid;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] cnt_hit;

    // Event 0 is reserved and never feeds a channel. Its slice is
    // intentionally left unused.
    logic unused_evt0;
    assign unused_evt0 = ^evt_inc_i[INC_W-1:0];

    // ------------------------------------------------------------------
    // Write decode
    // A channel index beyond NUM_CH (possible when NUM_CH is not a power
    // of two) addresses nothing, so such a write is dropped.
    // ------------------------------------------------------------------
    assign ch_valid = (32'(cfg_ch_i) < 32'(NUM_CH));

    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch is
        // inferred.
        cfg_hit = '0;
        cnt_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_hit[c] = cfg_we_i && ch_valid && (cfg_ch_i == CH_W'(c));
            cnt_hit[c] = cnt_we_i && ch_valid && (cfg_ch_i == CH_W'(c));
        end
    end

    // ------------------------------------------------------------------
    // Channel configuration registers
    // A new select takes effect for events from the next cycle onward. An
    // increment already captured from the old source still drains through
    // stage 2.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: the per-channel arrays are small flop banks, not RAM. The
        // reset state defines every one of them, so they are reset
        // explicitly here.
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sel_q[c] <= '0;
            end
            en_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_hit[c]) begin
                    sel_q[c] <= cfg_sel_i;
                    en_q[c]  <= cfg_en_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: select and gate the increment
    // The loop compares against legal non-zero event indices only. A select
    // of 0, or one at or above NUM_EVT, matches nothing and yields 0. No
    // out-of-range part-select can occur.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            inc_d[c] = '0;
            if (en_q[c] && !freeze_i) begin
                for (int e = 1; e < NUM_EVT; e++) begin
                    if (sel_q[c] == SEL_W'(e)) begin
                        inc_d[c] = evt_inc_i[e*INC_W +: INC_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is written only with non-blocking
        // assignments. Every flop then samples pre-edge values, whatever
        // order the blocks run in.
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                inc_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                inc_q[c] <= inc_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate, wrap and overflow
    // A preload replaces the channel's sum, so that channel's captured
    // increment is dropped and cannot raise an overflow. The clear applies
    // independently of the preload. A wrap in the same cycle as a clear
    // still leaves the flag set.
    // ------------------------------------------------------------------
    always_comb begin
        ovf_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c]   = {1'b0, cnt_q[c]} + (CNT_W+1)'(inc_q[c]);
            cnt_d[c] = cnt_hit[c] ? cnt_wdata_i : sum[c][CNT_W-1:0];
            ovf_d[c] = (sum[c][CNT_W] && !cnt_hit[c])
                     || (ovf_q[c] && !ovf_clr_i[c]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt_out
        assign cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end

    assign ovf_o = ovf_q;

`ifdef EVU_OVF_IRQ_EN
    // The interrupt follows the registered flags, one cycle behind them.
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |ovf_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_evu_counter_bank.sv
// ============================================================================
// tb_evu_counter_bank
// Self-checking bench for evu_counter_bank. It has three parts:
//   - hand-written sequences: reset, basic counting, latency, reset in flight;
//   - a table of per-cycle vectors on channel 0: wrap, sticky overflow,
//     clear-vs-set, preload priority, freeze, reserved event 0;
//   - randomized traffic compared cycle by cycle against a behavioural model.
// ============================================================================
module tb_evu_counter_bank;

    localparam int NUM_CH  = 4;
    localparam int NUM_EVT = 16;
    localparam int CNT_W   = 64;
    localparam int INC_W   = 2;

`ifdef EVU_OVF_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_EVT*INC_W-1:0] evt_inc;
    logic                     freeze;
    logic                     cfg_we;
    logic [1:0]               cfg_ch;
    logic [3:0]               cfg_sel;
    logic                     cfg_en;
    logic                     cnt_we;
    logic [CNT_W-1:0]         cnt_wdata;
    logic [NUM_CH-1:0]        ovf_clr;
    logic [NUM_CH*CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0]        ovf;
    logic                     irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    evu_counter_bank #(
        .NUM_CH (NUM_CH),
        .NUM_EVT(NUM_EVT),
        .CNT_W  (CNT_W),
        .INC_W  (INC_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .evt_inc_i  (evt_inc),
        .freeze_i   (freeze),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_sel_i  (cfg_sel),
        .cfg_en_i   (cfg_en),
        .cnt_we_i   (cnt_we),
        .cnt_wdata_i(cnt_wdata),
        .ovf_clr_i  (ovf_clr),
        .cnt_o      (cnt),
        .ovf_o      (ovf),
        .irq_o      (irq)
    );

    // ------------------------------------------------------------------
    // Behavioural model. Each channel holds its counter value and the one
    // increment "in the pipe". The pipe content is what was selected in
    // the previous cycle, and it lands on the counter at the next edge.
    // ------------------------------------------------------------------
    logic [63:0]       m_cnt  [NUM_CH];
    int unsigned       m_pend [NUM_CH];
    int                m_sel  [NUM_CH];
    bit                m_en   [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    bit                m_irq;

    function automatic int unsigned evt_of(int e);
        return int'(evt_inc[e*INC_W +: INC_W]);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c]  = '0;
                m_pend[c] = 0;
                m_sel[c]  = 0;
                m_en[c]   = 0;
            end
            m_ovf = '0;
            m_irq = 0;
        end else begin
            m_irq = IRQ_ON && (m_ovf != '0);
            for (int c = 0; c < NUM_CH; c++) begin
                logic [64:0] full;
                bit          hit_cnt;
                bit          wrap;
                int unsigned nxt;
                hit_cnt = cnt_we && (int'(cfg_ch) == c);
                full    = {1'b0, m_cnt[c]} + 65'(m_pend[c]);
                wrap    = !hit_cnt && full[64];
                m_cnt[c] = hit_cnt ? cnt_wdata : full[63:0];
                if (wrap)
                    m_ovf[c] = 1'b1;
                else if (ovf_clr[c])
                    m_ovf[c] = 1'b0;
                nxt = 0;
                if (m_en[c] && !freeze && m_sel[c] >= 1 && m_sel[c] < NUM_EVT)
                    nxt = evt_of(m_sel[c]);
                m_pend[c] = nxt;
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    m_sel[c] = int'(cfg_sel);
                    m_en[c]  = cfg_en;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cnt_of(int c);
        return cnt[c*CNT_W +: CNT_W];
    endfunction

    // Inputs change 1 ns after the edge, and outputs are sampled there too.
    // The model advances on the edge from the inputs that were stable
    // across it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        evt_inc   = '0;
        freeze    = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_sel   = '0;
        cfg_en    = 1'b0;
        cnt_we    = 1'b0;
        cnt_wdata = '0;
        ovf_clr   = '0;
    endtask

    task automatic write_cfg(input int ch, input int sel, input bit en);
        set_idle();
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_sel = 4'(sel);
        cfg_en  = en;
        tick();
        set_idle();
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s cnt%0d", tag, c), cnt_of(c), m_cnt[c]);
        check({tag, " ovf"}, 64'(ovf), 64'(m_ovf));
        check({tag, " irq"}, 64'(irq), 64'(m_irq));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (channel 0 only, expected values after the edge)
    // ------------------------------------------------------------------
    typedef struct {
        bit          cfg_we;
        logic [3:0]  sel;
        bit          en;
        bit          cnt_we;
        logic [63:0] wdata;
        logic [31:0] evt;
        bit          freeze;
        bit          clr0;
        logic [63:0] exp_cnt0;
        bit          exp_ovf0;
        bit          exp_irq;   // value when the interrupt is built in
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(bit cw, int sel, bit en, bit nw, logic [63:0] wd,
                                logic [31:0] ev, bit fr, bit cl,
                                logic [63:0] ec, bit eo, bit ei);
        vec_t v;
        v.cfg_we = cw;  v.sel = 4'(sel); v.en = en;
        v.cnt_we = nw;  v.wdata = wd;
        v.evt = ev;     v.freeze = fr;   v.clr0 = cl;
        v.exp_cnt0 = ec; v.exp_ovf0 = eo; v.exp_irq = ei;
        return v;
    endfunction

    // Event-1 slice encodings used in the table: 32'h4 -> 1, 32'h8 -> 2, 32'hC -> 3
    initial begin
        //            cw sel en  nw wdata      evt           fr cl  cnt0       ovf irq
        vecs[0]  = mk(1, 1, 1,   0, 64'd0,     32'h0,        0, 0,  64'd0,     0,  0);
        vecs[1]  = mk(0, 0, 0,   1, MAX,       32'h8,        0, 0,  MAX,       0,  0);
        vecs[2]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd1,     1,  0);
        vecs[3]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd1,     1,  1);
        vecs[4]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 1,  64'd1,     0,  1);
        vecs[5]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd1,     0,  0);
        vecs[6]  = mk(0, 0, 0,   1, MAX - 1,   32'hC,        0, 0,  MAX - 1,   0,  0);
        vecs[7]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd1,     1,  0);
        vecs[8]  = mk(0, 0, 0,   1, MAX,       32'h4,        0, 0,  MAX,       1,  1);
        vecs[9]  = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 1,  64'd0,     1,  1);
        vecs[10] = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd0,     1,  1);
        vecs[11] = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 1,  64'd0,     0,  1);
        vecs[12] = mk(0, 0, 0,   0, 64'd0,     32'h4,        0, 0,  64'd0,     0,  0);
        vecs[13] = mk(0, 0, 0,   1, 64'd100,   32'h0,        0, 0,  64'd100,   0,  0);
        vecs[14] = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd100,   0,  0);
        vecs[15] = mk(0, 0, 0,   0, 64'd0,     32'h4,        0, 0,  64'd100,   0,  0);
        vecs[16] = mk(0, 0, 0,   0, 64'd0,     32'h4,        1, 0,  64'd101,   0,  0);
        vecs[17] = mk(0, 0, 0,   0, 64'd0,     32'h4,        1, 0,  64'd101,   0,  0);
        vecs[18] = mk(0, 0, 0,   0, 64'd0,     32'h4,        0, 0,  64'd101,   0,  0);
        vecs[19] = mk(0, 0, 0,   0, 64'd0,     32'h0,        0, 0,  64'd102,   0,  0);
        vecs[20] = mk(1, 0, 1,   0, 64'd0,     32'h0,        0, 0,  64'd102,   0,  0);
        vecs[21] = mk(0, 0, 0,   0, 64'd0,     32'hFFFF_FFFF, 0, 0, 64'd102,   0,  0);
        vecs[22] = mk(0, 0, 0,   0, 64'd0,     32'hFFFF_FFFF, 0, 0, 64'd102,   0,  0);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("reset cnt%0d", c), cnt_of(c), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset irq", 64'(irq), 64'd0);
        rst_n = 1'b1;

        // --- Count the cycle event on channel 0 for 10 cycles ------------
        write_cfg(0, 1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            evt_inc[1*INC_W +: INC_W] = 2'd1;
            tick();
            if (i == 1) check("t1 first edge", cnt_of(0), 64'd0);
            if (i == 2) check("t1 latency2", cnt_of(0), 64'd1);
        end
        set_idle();
        check("t1 after last event edge", cnt_of(0), 64'd9);
        tick();
        check("t1 cnt0", cnt_of(0), 64'd10);
        for (int c = 1; c < NUM_CH; c++)
            check($sformatf("t1 other cnt%0d", c), cnt_of(c), 64'd0);

        // --- Channel 1 on event 6, channel 2 on reserved event 0 ---------
        write_cfg(1, 6, 1'b1);
        write_cfg(2, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            evt_inc[6*INC_W +: INC_W] = 2'd2;
            evt_inc[0 +: INC_W]       = 2'd3;
            tick();
        end
        set_idle();
        check("t2 cnt1 mid", cnt_of(1), 64'd4);
        tick();
        check("t2 cnt1", cnt_of(1), 64'd6);
        check("t2 cnt2 sel0", cnt_of(2), 64'd0);
        check("t2 cnt0 held", cnt_of(0), 64'd10);
        check("t2 cnt3", cnt_of(3), 64'd0);

        // --- Reset with an increment in flight ---------------------------
        evt_inc[1*INC_W +: INC_W] = 2'd3;
        tick();
        set_idle();
        rst_n = 1'b0;
        tick();
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("t6 rst cnt%0d", c), cnt_of(c), 64'd0);
        check("t6 rst ovf", 64'(ovf), 64'd0);
        check("t6 rst irq", 64'(irq), 64'd0);
        rst_n = 1'b1;
        evt_inc[1*INC_W +: INC_W] = 2'd1;   // channels are disabled after reset
        tick();
        tick();
        set_idle();
        tick();
        check("t6 inflight dropped", cnt_of(0), 64'd0);

        // --- Table-driven corner cases on channel 0 ----------------------
        for (int i = 0; i < NVEC; i++) begin
            set_idle();
            cfg_we     = vecs[i].cfg_we;
            cfg_ch     = 2'd0;
            cfg_sel    = vecs[i].sel;
            cfg_en     = vecs[i].en;
            cnt_we     = vecs[i].cnt_we;
            cnt_wdata  = vecs[i].wdata;
            evt_inc    = vecs[i].evt;
            freeze     = vecs[i].freeze;
            ovf_clr[0] = vecs[i].clr0;
            tick();
            check($sformatf("vec%0d cnt0", i), cnt_of(0), vecs[i].exp_cnt0);
            check($sformatf("vec%0d ovf0", i), 64'(ovf[0]), 64'(vecs[i].exp_ovf0));
            check($sformatf("vec%0d irq", i), 64'(irq), 64'(IRQ_ON && vecs[i].exp_irq));
        end
        set_idle();

        // --- Preload on channel 3 beats its in-flight increment, then freeze
        write_cfg(3, 1, 1'b1);
        evt_inc[1*INC_W +: INC_W] = 2'd1;
        tick();
        set_idle();
        cnt_we    = 1'b1;
        cfg_ch    = 2'd3;
        cnt_wdata = 64'd100;
        tick();
        set_idle();
        check("t5 preload cnt3", cnt_of(3), 64'd100);
        tick();
        check("t5 preload held", cnt_of(3), 64'd100);
        evt_inc[1*INC_W +: INC_W] = 2'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            freeze = 1'b1;
            tick();
        end
        set_idle();
        check("t5 freeze cnt3", cnt_of(3), 64'd101);
        tick();
        check("t5 after freeze", cnt_of(3), 64'd101);

        // --- Randomized traffic against the model ------------------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst_n   = ($urandom_range(0, 399) != 0);
            evt_inc = $urandom;
            freeze  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cfg_we  = 1'b1;
                cfg_sel = 4'($urandom_range(0, 15));
                cfg_en  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 15) == 0) begin
                cnt_we = 1'b1;
                case ($urandom_range(0, 2))
                    0:       cnt_wdata = {$urandom, $urandom};
                    1:       cnt_wdata = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom)};
                    default: cnt_wdata = 64'($urandom_range(0, 255));
                endcase
            end
            cfg_ch = 2'($urandom_range(0, 3));
            for (int c = 0; c < NUM_CH; c++)
                ovf_clr[c] = ($urandom_range(0, 7) == 0);
            tick();
            check_model($sformatf("rnd%0d", n));
        end
        set_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
